fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Drains 8-bit words from the read side of async_fifo and serialises them as
//  8N1 UART frames (optional 2 stop bits, optional even parity). Sits directly
//  downstream of the FIFO in the rd_clk domain and owns the FIFO's rd_en/empty/dout.
//  Includes CTS flow control and a busy flag for board-level status.
// PARAMETERS
//  clk_freq    100000000  input clock frequency, Hz
//  baud_rate   115200     line rate, bit/s
//  data_width  8          bits per frame; must equal the FIFO data_width
//  stop_bits   1          number of stop bits, 1 or 2
//  cycles_per_bit = clk_freq/baud_rate (truncated); elaboration error if < 2
// PORTS
//  clk         in   1           clock; same clock as the FIFO rd_clk
//  rst_n       in   1           asynchronous active-low reset
//  fifo_empty  in   1           FIFO empty flag
//  fifo_dout   in   data_width  FIFO read data; valid the cycle after fifo_rd_en
//  fifo_rd_en  out  1           FIFO pop strobe; one-cycle pulse per word
//  cts_n       in   1           clear-to-send, active low; pre-synchronised
//  tx          out  1           serial line; idles high; registered
//  busy        out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset (async): tx=1, fifo_rd_en=0, busy=0, state=IDLE, counters=0.
//  States: IDLE -> FETCH -> START -> DATA -> [PARITY] -> STOP -> IDLE|FETCH.
//  IDLE: if fifo_empty==0 && cts_n==0, assert fifo_rd_en for this cycle and go to FETCH.
//  FETCH: 1 clk, tx=1; latch fifo_dout into the shift register; go to START.
//  START: tx=0 for cycles_per_bit clks. DATA: data_width bits, LSB first, each
//  held for cycles_per_bit clks. STOP: tx=1 for stop_bits*cycles_per_bit clks.
//  Last STOP clk: if fifo_empty==0 && cts_n==0, assert fifo_rd_en and go to FETCH;
//  else go to IDLE. Inter-frame gap when back-to-back = exactly 1 clk of tx=1 (FETCH).
//  Start-bit latency: start bit begins 2 clks after the IDLE clk that pops.
//  fifo_rd_en is never asserted while fifo_empty==1; never more than one pop per frame.
//  cts_n is sampled only at pop decisions; deasserting it mid-frame never aborts a frame.
//  Bit counter width `log2(data_width+1); baud counter width `log2(cycles_per_bit);
//  the baud counter reloads to 0 on every bit boundary (no drift accumulation).
//  Reset mid-frame: tx returns to 1 at once; the in-flight word is dropped, not re-popped.
// CONFIGURATION
//  FIFO_UART_TX_PARITY_EN defined: PARITY state between DATA and STOP; tx = even
//  parity (XOR of the data bits) for cycles_per_bit clks. Frame = (data_width+2+
//  stop_bits)*cycles_per_bit clks. Not defined: no PARITY state; frame =
//  (data_width+1+stop_bits)*cycles_per_bit clks. Ports are identical in both builds.
// STRUCTURE
//  util.vh (shared): `log2 macro, state localparam encodings (IDLE/FETCH/START/
//  DATA/PARITY/STOP) for reuse by the matching receiver.
//  Sub-module uart_baud_tick: counter emitting a 1-clk tick every cycles_per_bit
//  clks, with a sync clear input driven on FETCH; the FSM and shifter stay in the top module.
// TESTING (clk_freq=1000000, baud_rate=100000 -> 10 clks/bit; stop_bits=1)
//  1 Reset held with fifo_empty=0 -> tx=1, busy=0, fifo_rd_en=0 throughout; release -> pop.
//  2 One word 8'hA5, empty falls at T -> rd_en pulse at T only; tx=0 from T+2 for 10 clks,
//    then 1,0,1,0,0,1,0,1 (10 clks each), stop 10 clks; busy falls at T+102.
//  3 Words 8'h00 then 8'hFF queued -> rd_en pulses 101 clks apart; exactly 1 idle clk between frames.
//  4 cts_n=1 with fifo non-empty -> no rd_en for 500 clks; drop cts_n -> frame starts;
//    raise cts_n mid-frame -> frame completes, no further pop.
//  5 FIFO_UART_TX_PARITY_EN, word 8'h07 -> parity bit 1 after bit 7; frame 110 clks.
//  6 rst_n low during DATA bit 3 -> tx=1, busy=0 same clk; after release, next word sent intact.

Source files
------------

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared definitions for the FIFO-fed UART transmitter.
//   state_t   - FSM state encodings (IDLE/FETCH/START/DATA/PARITY/STOP), kept
//               here so the matching receiver can reuse the same values.
//   cnt_width - bits needed for a counter running 0..n-1 (never below 1).
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// uart_baud_tick: bit-period timer. Emits a 1-clk tick on the last clock of
// every cycles_per_bit window. Restarts from zero on each tick, so bit
// boundaries never drift.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   clear  in   synchronous restart; the next clock is the first of a bit
//   tick   out  last clock of the current bit period
module uart_baud_tick
    import fifo_uart_tx_pkg::*;
#(
    parameter int cycles_per_bit = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(cycles_per_bit);
    localparam logic [CW-1:0] LAST = CW'(cycles_per_bit - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops 8-bit words from an async FIFO read port and sends them
// as UART frames (start, data LSB first, optional even parity, 1 or 2 stops).
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bits.
//   clk         in   clock (the FIFO rd_clk)
//   rst_n       in   asynchronous active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the clock after fifo_rd_en
//   fifo_rd_en  out  one-clock pop strobe, at most one per frame
//   cts_n       in   clear-to-send (active low, already synchronised)
//   tx          out  registered serial line, idles high
//   busy        out  high whenever the FSM is not in IDLE
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int clk_freq   = 100000000,
    parameter int baud_rate  = 115200,
    parameter int data_width = 8,
    parameter int stop_bits  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    input  logic                  cts_n,
    output logic                  tx,
    output logic                  busy
);

    localparam int CPB = clk_freq / baud_rate;
    localparam int BW  = $clog2(data_width + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(data_width - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(stop_bits - 1);

    generate
        if (CPB < 2) begin : g_bad_cpb
            $error("fifo_uart_tx: clk_freq/baud_rate must be at least 2");
        end
        if (stop_bits != 1 && stop_bits != 2) begin : g_bad_stop
            $error("fifo_uart_tx: stop_bits must be 1 or 2");
        end
    endgenerate

    state_t                state, state_next;
    logic [data_width-1:0] shreg;
    logic [BW-1:0]         bit_cnt;
    logic                  tick;
    logic                  tx_d;
    logic                  can_pop;
    logic                  last_stop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  par;
`endif

    assign can_pop   = !fifo_empty && !cts_n;
    assign last_stop = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);
    assign busy      = (state != ST_IDLE);

    // Restarting the timer in FETCH aligns the start bit to a full period.
    uart_baud_tick #(.cycles_per_bit(CPB)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == ST_FETCH),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (can_pop) state_next = ST_FETCH;
            ST_FETCH:  state_next = ST_START;
            ST_START:  if (tick) state_next = ST_DATA;
            ST_DATA:
                if (tick && bit_cnt == LAST_DATA) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            ST_PARITY: if (tick) state_next = ST_STOP;
            ST_STOP:   if (last_stop) state_next = can_pop ? ST_FETCH : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // tx is registered, so tx_d is the line level for the state being entered.
    // On a data-bit boundary the shifter moves at the same edge, hence shreg[1].
    always_comb begin
        fifo_rd_en = rst_n && can_pop && (state == ST_IDLE || last_stop);
        tx_d       = 1'b1;
        case (state_next)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = (state == ST_DATA && tick) ? shreg[1] : shreg[0];
`ifdef FIFO_UART_TX_PARITY_EN
            ST_PARITY: tx_d = par;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx      <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            tx <= tx_d;
            if (state == ST_FETCH) begin
                shreg <= fifo_dout;
`ifdef FIFO_UART_TX_PARITY_EN
                par   <= ^fifo_dout;
`endif
            end else if (state == ST_DATA && tick) begin
                shreg <= shreg >> 1;
            end
            // bit_cnt indexes data bits in DATA and stop bits in STOP.
            if (state_next != state)
                bit_cnt <= '0;
            else if (tick && (state == ST_DATA || state == ST_STOP))
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule
